// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS datapath
//
// Sequences FETCH / DECODE / execute / memory / write-back for each
// instruction and drives every datapath select and enable.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   op             IR[31:26], valid from DECODE onward
//   mem_ready      memory completes the current read/write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero (beq)
//   pc_src         00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d         memory address: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load
//   reg_dst        register destination: 0 rt, 1 rd
//   mem_to_reg     write-back source: 0 ALUOut, 1 MDR
//   reg_write      register file write enable
//   alu_src_a      ALU A: 0 PC, 1 rs
//   alu_src_b      ALU B: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//   alu_op         00 add, 01 sub, 10 funct, 11 immediate-op
//   ext_op         immediate extender: 1 sign-extend, 0 zero-extend
//   illegal        one-cycle pulse on an unknown opcode / bad state
//   state          current state encoding (debug)
//
// Build option:
//   LOGIC_IMM_ZEXT_EN  when defined, andi/ori/xori zero-extend their
//                      immediate (ext_op=0 in LOGIEX); otherwise ext_op
//                      is 1 in every state.

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_LOGIEX = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] cur_state;
    logic [3:0] next_state;
    logic [3:0] out_state;
    logic       op_legal;

    // Raw (ungated) enables from the state decode.
    logic raw_pc_write;
    logic raw_pc_write_cond;
    logic raw_ir_write;
    logic raw_reg_write;
    logic raw_mem_read;
    logic raw_mem_write;
    logic raw_illegal;

    assign state = cur_state;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:             next_state = S_MEMADR;
                    OP_RTYPE:                 next_state = S_EXEC;
                    OP_BEQ:                   next_state = S_BRANCH;
                    OP_J:                     next_state = S_JUMP;
                    OP_ADDI, OP_SLTI:         next_state = S_ADDIEX;
                    OP_ANDI, OP_ORI, OP_XORI: next_state = S_LOGIEX;
                    default:                  next_state = S_FETCH;
                endcase
            end
            // IR is not reloaded until the next FETCH, so op is still valid here.
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_IWB;
            S_IWB:    next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_LOGIEX: next_state = S_IWB;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // While reset is asserted the state register may not yet be FETCH, so
    // the mux selects are decoded as if it were; enables are gated below.
    assign out_state = reset ? S_FETCH : cur_state;

    always_comb begin
        raw_pc_write      = 1'b0;
        raw_pc_write_cond = 1'b0;
        raw_ir_write      = 1'b0;
        raw_reg_write     = 1'b0;
        raw_mem_read      = 1'b0;
        raw_mem_write     = 1'b0;
        raw_illegal       = 1'b0;
        pc_src            = 2'b00;
        i_or_d            = 1'b0;
        reg_dst           = 1'b0;
        mem_to_reg        = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = 2'b00;
        alu_op            = 2'b00;
        ext_op            = 1'b1;
        case (out_state)
            S_FETCH: begin
                raw_mem_read = 1'b1;
                // IR and PC load only on the cycle the read actually completes.
                raw_ir_write = mem_ready;
                raw_pc_write = mem_ready;
                alu_src_b    = 2'b01;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (sext(imm) << 2).
                alu_src_b   = 2'b11;
                raw_illegal = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                raw_mem_read = 1'b1;
                i_or_d       = 1'b1;
            end
            S_MEMWB: begin
                raw_reg_write = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEMWR: begin
                raw_mem_write = 1'b1;
                i_or_d        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                raw_reg_write = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a         = 1'b1;
                alu_op            = 2'b01;
                raw_pc_write_cond = 1'b1;
                pc_src            = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_IWB: begin
                raw_reg_write = 1'b1;
            end
            S_JUMP: begin
                raw_pc_write = 1'b1;
                pc_src       = 2'b10;
            end
            S_LOGIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
`ifdef LOGIC_IMM_ZEXT_EN
                ext_op    = 1'b0;
`else
                ext_op    = 1'b1;
`endif
            end
            default: begin
                // Encodings 13-15 are unreachable in normal operation.
                raw_illegal = 1'b1;
            end
        endcase
    end

    // Reset aborts any in-flight access: no request, load or write escapes.
    assign pc_write      = raw_pc_write      & ~reset;
    assign pc_write_cond = raw_pc_write_cond & ~reset;
    assign ir_write      = raw_ir_write      & ~reset;
    assign reg_write     = raw_reg_write     & ~reset;
    assign mem_read      = raw_mem_read      & ~reset;
    assign mem_write     = raw_mem_write     & ~reset;
    assign illegal       = raw_illegal       & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .ext_op(ext_op), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // mux vector: [10:9] pc_src [8] i_or_d [7] reg_dst [6] mem_to_reg
    //             [5] alu_src_a [4:3] alu_src_b [2:1] alu_op [0] ext_op
    typedef struct packed {
        logic [10:0] val;
        logic [10:0] mask;
    } mux_t;

    typedef struct {
        logic [3:0] st;
        logic [6:0] en;   // {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, illegal}
        mux_t       mux;
        string      name;
    } exp_t;

    exp_t scoreboard[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef LOGIC_IMM_ZEXT_EN
    localparam int LOGI_EXT = 0;
`else
    localparam int LOGI_EXT = 1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Negative argument means the field is unspecified in that state.
    function automatic mux_t mx(int pcs, int iod, int rd, int m2r, int a, int b, int aop, int ext);
        mux_t r;
        r = '0;
        if (pcs >= 0) begin r.val[10:9] = pcs[1:0]; r.mask[10:9] = 2'b11; end
        if (iod >= 0) begin r.val[8]    = iod[0];   r.mask[8]    = 1'b1;  end
        if (rd  >= 0) begin r.val[7]    = rd[0];    r.mask[7]    = 1'b1;  end
        if (m2r >= 0) begin r.val[6]    = m2r[0];   r.mask[6]    = 1'b1;  end
        if (a   >= 0) begin r.val[5]    = a[0];     r.mask[5]    = 1'b1;  end
        if (b   >= 0) begin r.val[4:3]  = b[1:0];   r.mask[4:3]  = 2'b11; end
        if (aop >= 0) begin r.val[2:1]  = aop[1:0]; r.mask[2:1]  = 2'b11; end
        if (ext >= 0) begin r.val[0]    = ext[0];   r.mask[0]    = 1'b1;  end
        return r;
    endfunction

    function automatic bit known_op(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b000010) || (o == 6'b001000) ||
               (o == 6'b001010) || (o == 6'b001100) || (o == 6'b001101) ||
               (o == 6'b001110);
    endfunction

    function automatic mux_t exp_mux(input logic [3:0] st, input bit rst);
        //                 pcs iod rd m2r  a   b  aop ext
        if (rst) return mx( 0,  0, -1, -1,  0,  1,  0,  1);
        case (st)
            4'd0:  return mx( 0,  0, -1, -1,  0,  1,  0,  1);
            4'd1:  return mx(-1, -1, -1, -1,  0,  3, -1,  1);
            4'd2:  return mx(-1, -1, -1, -1,  1,  2,  0,  1);
            4'd3:  return mx(-1,  1, -1, -1, -1, -1, -1,  1);
            4'd4:  return mx(-1, -1,  0,  1, -1, -1, -1,  1);
            4'd5:  return mx(-1,  1, -1, -1, -1, -1, -1,  1);
            4'd6:  return mx(-1, -1, -1, -1,  1,  0,  2,  1);
            4'd7:  return mx(-1, -1,  1,  0, -1, -1, -1,  1);
            4'd8:  return mx( 1, -1, -1, -1,  1,  0,  1,  1);
            4'd9:  return mx(-1, -1, -1, -1,  1,  2,  3,  1);
            4'd10: return mx(-1, -1,  0,  0, -1, -1, -1,  1);
            4'd11: return mx( 2, -1, -1, -1, -1, -1, -1,  1);
            4'd12: return mx(-1, -1, -1, -1,  1,  2,  3, LOGI_EXT);
            default: return mx(-1, -1, -1, -1, -1, -1, -1, 1);
        endcase
    endfunction

    function automatic logic [6:0] exp_en(input logic [3:0] st, input bit mr, input logic [5:0] o, input bit rst);
        if (rst) return 7'b0;
        case (st)
            4'd0:  return {mr, 1'b0, mr, 1'b0, 1'b1, 1'b0, 1'b0};
            4'd1:  return {6'b0, ~known_op(o)};
            4'd3:  return 7'b0000100;
            4'd4:  return 7'b0001000;
            4'd5:  return 7'b0000010;
            4'd7:  return 7'b0001000;
            4'd8:  return 7'b0100000;
            4'd10: return 7'b0001000;
            4'd11: return 7'b1000000;
            4'd2, 4'd6, 4'd9, 4'd12: return 7'b0;
            default: return 7'b0000001;
        endcase
    endfunction

    // Drive one cycle's inputs, push its expectation, compare at the falling edge.
    task automatic step(input bit rst, input logic [3:0] st, input bit mr, input logic [5:0] o, input string name);
        exp_t e, got;
        logic [10:0] obs_mux;
        reset     = rst;
        mem_ready = mr;
        op        = o;
        e.st   = st;
        e.en   = exp_en(st, mr, o, rst);
        e.mux  = exp_mux(st, rst);
        e.name = $sformatf("%s/st%0d", name, st);
        scoreboard.push_back(e);
        @(negedge clk);
        got = scoreboard.pop_front();
        obs_mux = {pc_src, i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op};
        check({got.name, " state"}, 32'(state), 32'(got.st));
        check({got.name, " en"},
              32'({pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, illegal}),
              32'(got.en));
        check({got.name, " mux"}, 32'(obs_mux & got.mux.mask), 32'(got.mux.val & got.mux.mask));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] hexval(input byte c);
        if (c <= 8'h39) return 4'(c - 8'h30);
        return 4'(c - 8'h61 + 8'd10);
    endfunction

    // sts: expected state per cycle (hex chars); mrs: mem_ready per cycle.
    task automatic run(input logic [5:0] o, input string sts, input string mrs, input string name);
        for (int i = 0; i < sts.len(); i++) begin
            step(1'b0, hexval(sts[i]), (mrs[i] == 8'h31), o, name);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = 6'b000000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 1'b1, 6'b000000, "reset");

        run(6'b100011, "01234",   "11111",   "lw");
        run(6'b101011, "0125555", "1110001", "sw_wait");
        run(6'b100011, "0001234", "0011111", "lw_fwait");
        run(6'b100011, "0123334", "1110011", "lw_mwait");
        run(6'b000000, "0167",    "1111",    "rtype");
        run(6'b001000, "019a",    "1111",    "addi");
        run(6'b001010, "019a",    "1111",    "slti");
        run(6'b001101, "01ca",    "1111",    "ori");
        run(6'b001100, "01ca",    "1111",    "andi");
        run(6'b001110, "01ca",    "1111",    "xori");
        run(6'b000100, "018",     "111",     "beq");
        run(6'b000010, "01b",     "111",     "j");
        run(6'b111111, "01",      "11",      "illegal");
        run(6'b010001, "01",      "11",      "illegal2");

        // Abort a lw while MEMRD waits; the held mem_ready must not complete it.
        run(6'b100011, "0123", "1110", "abort");
        step(1'b1, 4'd3, 1'b1, 6'b100011, "abort_rst");
        run(6'b000010, "01b0", "1111", "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
